// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Shares one combinational ALU between two requesters. Ops are
//                accepted over valid/ready with round-robin (or fixed) arbitration,
//                the latched operands drive the ALU for one cycle, and the
//                registered result/flags return on one ID-tagged response channel.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 4,
    parameter int FIX_PRIO = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    // requester 0
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_src1,
    input  logic [DATA_W-1:0] req0_src2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    // requester 1
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_src1,
    input  logic [DATA_W-1:0] req1_src2,
    input  logic [CTRL_W-1:0] req1_ctrl,
    // shared ALU
    output logic [DATA_W-1:0] alu_src1_o,
    output logic [DATA_W-1:0] alu_src2_o,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    input  logic [DATA_W-1:0] alu_result_i,
    input  logic [2:0]        alu_flags_i,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
    output logic [2:0]        rsp_flags
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              id_q, id_d;
    logic [DATA_W-1:0] src1_q, src1_d;
    logic [DATA_W-1:0] src2_q, src2_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [2:0]        rsp_flags_q, rsp_flags_d;

    logic              grant_valid;
    logic              grant_id;

    // Arbitration: pick the winner among valid requesters; ready only in IDLE.
    // Readies are also masked by reset so nothing is offered while it is held.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = (FIX_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        req0_ready = (state_q == ST_IDLE) && !rst_i && grant_valid && !grant_id;
        req1_ready = (state_q == ST_IDLE) && !rst_i && grant_valid &&  grant_id;
    end

    // Next-state logic: accept in IDLE, capture ALU output in ISSUE, hold in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        ctrl_d       = ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_valid && req0_ready) begin
                    src1_d       = req0_src1;
                    src2_d       = req0_src2;
                    ctrl_d       = req0_ctrl;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ST_ISSUE;
                end else if (req1_valid && req1_ready) begin
                    src1_d       = req1_src1;
                    src2_d       = req1_src2;
                    ctrl_d       = req1_ctrl;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                rsp_result_d = alu_result_i;
                rsp_flags_d  = alu_flags_i;
                rsp_id_d     = id_q;
                rsp_valid_d  = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                // Response data stays put after the handshake; only valid drops.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; reset discards any in-flight op or pending response.
    // last_grant resets to 1 so port 0 wins the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            src1_q       <= '0;
            src2_q       <= '0;
            ctrl_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            ctrl_q       <= ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    // The ALU sees the latched op continuously; it is only sampled in ISSUE.
    assign alu_src1_o = src1_q;
    assign alu_src2_o = src2_q;
    assign alu_ctrl_o = ctrl_q;

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter. A round-robin
//                instance and a fixed-priority instance share all stimulus, each
//                with its own behavioural ALU.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_valid = 1'b0, r1_valid = 1'b0;
    logic [31:0] r0_src1 = '0, r0_src2 = '0, r1_src1 = '0, r1_src2 = '0;
    logic [3:0]  r0_ctrl = '0, r1_ctrl = '0;
    logic        rsp_rdy = 1'b0;

    // round-robin instance
    logic        r0_ready, r1_ready, rsp_valid, rsp_id;
    logic [31:0] alu_s1, alu_s2, alu_res, rsp_result;
    logic [3:0]  alu_c;
    logic [2:0]  alu_fl, rsp_flags;

    // fixed-priority instance
    logic        f0_ready, f1_ready, f_rsp_valid, f_rsp_id;
    logic [31:0] f_alu_s1, f_alu_s2, f_alu_res, f_rsp_result;
    logic [3:0]  f_alu_c;
    logic [2:0]  f_alu_fl, f_rsp_flags;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {zero, cout, overflow, result}.
    // For subtract, cout is the borrow (a < b unsigned).
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        co;
        logic        ov;
        s  = '0;
        r  = '0;
        co = 1'b0;
        ov = 1'b0;
        case (c)
            4'b0010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0110: begin
                r  = a - b;
                co = (a < b);
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            default: r = '0;
        endcase
        return {(r == 32'd0), co, ov, r};
    endfunction

    assign {alu_fl, alu_res}     = alu_model(alu_s1, alu_s2, alu_c);
    assign {f_alu_fl, f_alu_res} = alu_model(f_alu_s1, f_alu_s2, f_alu_c);

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .FIX_PRIO(0)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid(r0_valid), .req0_ready(r0_ready),
        .req0_src1(r0_src1), .req0_src2(r0_src2), .req0_ctrl(r0_ctrl),
        .req1_valid(r1_valid), .req1_ready(r1_ready),
        .req1_src1(r1_src1), .req1_src2(r1_src2), .req1_ctrl(r1_ctrl),
        .alu_src1_o(alu_s1), .alu_src2_o(alu_s2), .alu_ctrl_o(alu_c),
        .alu_result_i(alu_res), .alu_flags_i(alu_fl),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags)
    );

    alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .FIX_PRIO(1)) dut_fp (
        .clk_i(clk), .rst_i(rst),
        .req0_valid(r0_valid), .req0_ready(f0_ready),
        .req0_src1(r0_src1), .req0_src2(r0_src2), .req0_ctrl(r0_ctrl),
        .req1_valid(r1_valid), .req1_ready(f1_ready),
        .req1_src1(r1_src1), .req1_src2(r1_src2), .req1_ctrl(r1_ctrl),
        .alu_src1_o(f_alu_s1), .alu_src2_o(f_alu_s2), .alu_ctrl_o(f_alu_c),
        .alu_result_i(f_alu_res), .alu_flags_i(f_alu_fl),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_rdy), .rsp_id(f_rsp_id),
        .rsp_result(f_rsp_result), .rsp_flags(f_rsp_flags)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Issue one op on one port, check accept, latency, response and handshake.
    task automatic do_op(input int idx, input logic port, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [2:0] ef);
        int k;
        if (port) begin
            r1_valid = 1'b1; r1_src1 = a; r1_src2 = b; r1_ctrl = c;
        end else begin
            r0_valid = 1'b1; r0_src1 = a; r0_src2 = b; r0_ctrl = c;
        end
        #1;
        k = 0;
        while (!(port ? r1_ready : r0_ready) && k < 10) begin
            tick();
            k++;
        end
        chk($sformatf("v%0d accept", idx), {31'd0, (port ? r1_ready : r0_ready)}, 32'd1);
        tick();                                    // accepted; now ISSUE
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        chk($sformatf("v%0d issue_rsp_valid", idx), {31'd0, rsp_valid}, 32'd0);
        tick();                                    // now RESP
        chk($sformatf("v%0d rsp_valid", idx), {31'd0, rsp_valid}, 32'd1);
        chk($sformatf("v%0d result", idx), rsp_result, er);
        chk($sformatf("v%0d flags", idx), {29'd0, rsp_flags}, {29'd0, ef});
        chk($sformatf("v%0d id", idx), {31'd0, rsp_id}, {31'd0, port});
        rsp_rdy = 1'b1;
        tick();
        chk($sformatf("v%0d rsp_drop", idx), {31'd0, rsp_valid}, 32'd0);
        rsp_rdy = 1'b0;
    endtask

    typedef struct {
        logic        port;
        logic [3:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] er;
        logic [2:0]  ef;   // {zero, cout, overflow}
    } vec_t;

    vec_t vecs[8];

    initial begin
        int g_rr[$];
        int g_fp[$];
        int exp_id[$];
        int f1_seen;
        int eid;

        // ---------------- hand-computed vector table ----------------
        vecs[0] = '{1'b0, 4'b0010, 32'd5,          32'd3,          32'd8,          3'b000};
        vecs[1] = '{1'b0, 4'b0110, 32'd5,          32'd5,          32'd0,          3'b100};
        vecs[2] = '{1'b1, 4'b0010, 32'hFFFF_FFFF,  32'd1,          32'd0,          3'b110};
        vecs[3] = '{1'b0, 4'b0010, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  3'b001};
        vecs[4] = '{1'b1, 4'b0110, 32'd3,          32'd5,          32'hFFFF_FFFE,  3'b010};
        vecs[5] = '{1'b0, 4'b0000, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  3'b000};
        vecs[6] = '{1'b1, 4'b0001, 32'h0F0F_0000,  32'h0000_F0F0,  32'h0F0F_F0F0,  3'b000};
        vecs[7] = '{1'b1, 4'b0110, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  3'b001};

        // ---------------- reset held 2 cycles, both valid ----------------
        rst = 1'b1;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        r0_src1 = 32'h1234; r1_src1 = 32'h5678;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rst%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd0);
            chk($sformatf("rst%0d rsp_id", i), {31'd0, rsp_id}, 32'd0);
            chk($sformatf("rst%0d rsp_result", i), rsp_result, 32'd0);
            chk($sformatf("rst%0d rsp_flags", i), {29'd0, rsp_flags}, 32'd0);
            chk($sformatf("rst%0d alu_src1", i), alu_s1, 32'd0);
            chk($sformatf("rst%0d alu_ctrl", i), {28'd0, alu_c}, 32'd0);
            chk($sformatf("rst%0d ready0", i), {31'd0, r0_ready}, 32'd0);
            chk($sformatf("rst%0d ready1", i), {31'd0, r1_ready}, 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst ready0", {31'd0, r0_ready}, 32'd1);
        chk("post_rst ready1", {31'd0, r1_ready}, 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();

        // ---------------- table-driven single ops ----------------
        for (int i = 0; i < 8; i++) begin
            do_op(i, vecs[i].port, vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].ef);
        end

        // ---------------- contention: both valid, rsp_ready held ----------------
        do_reset();
        r0_valid = 1'b1; r0_src1 = 32'd10; r0_src2 = 32'd1; r0_ctrl = 4'b0010;
        r1_valid = 1'b1; r1_src1 = 32'd20; r1_src2 = 32'd2; r1_ctrl = 4'b0010;
        rsp_rdy  = 1'b1;
        f1_seen  = 0;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (r0_ready) begin g_rr.push_back(0); exp_id.push_back(0); end
            if (r1_ready) begin g_rr.push_back(1); exp_id.push_back(1); end
            if (f0_ready) g_fp.push_back(0);
            if (f1_ready) begin g_fp.push_back(1); f1_seen++; end
            if (rsp_valid) begin
                eid = (exp_id.size() > 0) ? exp_id.pop_front() : -1;
                chk($sformatf("rr_rsp%0d id", c), {31'd0, rsp_id}, eid[31:0]);
                chk($sformatf("rr_rsp%0d result", c), rsp_result, (eid == 1) ? 32'd22 : 32'd11);
            end
            tick();
        end
        chk("rr grant count", g_rr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr grant%0d", i), (i < g_rr.size()) ? g_rr[i] : -1, i % 2);
        end
        chk("fp grant count", g_fp.size(), 32'd4);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("fp grant%0d", i), (i < g_fp.size()) ? g_fp[i] : -1, 32'd0);
        end
        chk("fp port1 starved", f1_seen, 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rsp_rdy  = 1'b0;
        tick();

        // ---------------- backpressure + operand hold on waiting port 1 ----------------
        do_reset();
        r0_valid = 1'b1; r0_src1 = 32'd9;     r0_src2 = 32'd4; r0_ctrl = 4'b0010;
        r1_valid = 1'b1; r1_src1 = 32'h111;   r1_src2 = 32'd1; r1_ctrl = 4'b0010;
        #1;
        chk("bp ready0", {31'd0, r0_ready}, 32'd1);
        tick();
        r0_valid = 1'b0;
        r1_src1  = 32'h222;
        tick();
        chk("bp rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("bp result", rsp_result, 32'd13);
        for (int i = 0; i < 4; i++) begin
            r1_src1 = 32'h300 + i;
            tick();
            chk($sformatf("bp%0d rsp_valid", i), {31'd0, rsp_valid}, 32'd1);
            chk($sformatf("bp%0d result", i), rsp_result, 32'd13);
            chk($sformatf("bp%0d flags", i), {29'd0, rsp_flags}, 32'd0);
            chk($sformatf("bp%0d id", i), {31'd0, rsp_id}, 32'd0);
            chk($sformatf("bp%0d ready0", i), {31'd0, r0_ready}, 32'd0);
            chk($sformatf("bp%0d ready1", i), {31'd0, r1_ready}, 32'd0);
        end
        rsp_rdy = 1'b1;
        r1_src1 = 32'h400;
        tick();                                    // handshake edge, now IDLE
        rsp_rdy = 1'b0;
        chk("bp after hs rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp after hs ready1", {31'd0, r1_ready}, 32'd1);
        tick();                                    // port 1 accepted with src1=0x400
        r1_src1  = 32'h999;
        r1_valid = 1'b0;
        tick();
        chk("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("hold result", rsp_result, 32'h401);
        chk("hold id", {31'd0, rsp_id}, 32'd1);
        rsp_rdy = 1'b1;
        tick();
        rsp_rdy = 1'b0;

        // ---------------- reset during ISSUE ----------------
        do_reset();
        r0_valid = 1'b1; r0_src1 = 32'd7; r0_src2 = 32'd7; r0_ctrl = 4'b0010;
        #1;
        chk("mid ready0", {31'd0, r0_ready}, 32'd1);
        tick();                                    // ISSUE, last_grant now 0
        r0_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rst_issue rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_issue alu_src1", alu_s1, 32'd0);
        rst = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #1;
        chk("rst_issue tie ready0", {31'd0, r0_ready}, 32'd1);
        chk("rst_issue tie ready1", {31'd0, r1_ready}, 32'd0);
        r1_valid = 1'b0;
        tick();                                    // port 0 accepted
        r0_valid = 1'b0;
        tick();                                    // RESP
        chk("pre_rst_resp rsp_valid", {31'd0, rsp_valid}, 32'd1);

        // ---------------- reset during RESP ----------------
        rst = 1'b1;
        tick();
        chk("rst_resp rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_resp rsp_result", rsp_result, 32'd0);
        rst = 1'b0;
        rsp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_resp quiet%0d", i), {31'd0, rsp_valid}, 32'd0);
        end
        rsp_rdy  = 1'b0;
        r0_valid = 1'b1;
        r1_valid = 1'b1;
        #1;
        chk("rst_resp tie ready0", {31'd0, r0_ready}, 32'd1);
        chk("rst_resp tie ready1", {31'd0, r1_ready}, 32'd0);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
